serial_subtractor: RTL and testbench

- Parameterized bit-serial subtractor computing d = a - b - bin, one bit per clock, LSB first.
- Serial, area-minimal counterpart of the team's parallel ripple adders: one full-adder cell reused WIDTH times instead of WIDTH instances.
- Sits in datapath blocks where latency is acceptable and area is not.
- Valid/ready handshake on both the operand and the result side.

---
 rtl/serial_subtractor_pkg.sv | 17 +
 rtl/serial_subtractor_cell.sv | 26 ++
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Package for serial_subtractor.
// Holds the controller state encoding and the reset value used for the
// result and shift registers.
// Optional build macro: SERIAL_SUBTRACTOR_ADD_MODE_EN. The package is the
// same in both builds.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Per-bit reset value of the result and operand shift registers.
  localparam logic RESULT_RST_BIT = 1'b0;

endpackage

// File: rtl/serial_subtractor_cell.sv
// Combinational 1-bit full-adder cell with an optional inversion of b.
// The serial subtractor reuses one of these for every bit position.
// Ports:
//   a, b   operand bits
//   c      carry in
//   inv_b  1: use ~b (subtract), 0: use b (add)
//   s      sum bit
//   co     carry out
// Optional build macro: SERIAL_SUBTRACTOR_ADD_MODE_EN. The cell is the same
// in both builds.
module serial_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_b,
  output logic s,
  output logic co
);

  logic bx;

  assign bx = b ^ inv_b;
  assign s  = a ^ bx ^ c;
  assign co = (a & bx) | (a & c) | (bx & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, one bit per clock, LSB first.
// Internally it computes a + ~b + ~bin with a single full-adder cell.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   a, b, bin           minuend, subtrahend, borrow in
//   out_valid, out_ready result handshake; the result is held until accepted
//   d                   difference modulo 2^WIDTH
//   bout                unsigned borrow out (a < b + bin)
//   ovf                 two's-complement overflow
// Optional build macro: SERIAL_SUBTRACTOR_ADD_MODE_EN adds the input op, which
// is latched at acceptance. op=1 computes a + b + bin: bout then reports the
// carry out and ovf reports signed add overflow. op=0 subtracts.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  ,
  input  logic             op
`endif
);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;
  logic             sub;
  logic             s;
  logic             co;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic sub_q;
  assign sub = sub_q;
`else
  assign sub = 1'b1;
`endif

  serial_subtractor_cell u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .inv_b (sub),
    .s     (s),
    .co    (co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      d         <= {WIDTH{RESULT_RST_BIT}};
      bout      <= 1'b0;
      ovf       <= 1'b0;
      a_sh      <= {WIDTH{RESULT_RST_BIT}};
      b_sh      <= {WIDTH{RESULT_RST_BIT}};
      carry     <= 1'b0;
      cnt       <= '0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            a_msb    <= a[WIDTH-1];
            b_msb    <= b[WIDTH-1];
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            sub_q    <= ~op;
            // Subtract starts from ~bin, add starts from bin.
            carry    <= bin ^ ~op;
`else
            carry    <= ~bin;
`endif
          end
        end
        BUSY: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          d     <= {s, d[WIDTH-1:1]};
          carry <= co;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // s is the result MSB on this last bit. A subtract borrow is
            // the inverted carry; in add mode the carry is reported as is.
            bout      <= co ^ sub;
            ovf       <= (sub ? (a_msb != b_msb) : (a_msb == b_msb)) && (s != a_msb);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] d;
  logic       bout;
  logic       ovf;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic       op = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct {
    int d;
    int bout;
    int ovf;
  } res_t;

  res_t exp_q[$];

  serial_subtractor #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    ,
    .op        (op)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference result from plain integer arithmetic on 4-bit operands.
  function automatic res_t model(input int ia, input int ib, input int ibin);
    res_t r;
    int sa, sb, diff;
    r.d    = (ia - ib - ibin) & 15;
    r.bout = (ia < ib + ibin) ? 1 : 0;
    sa     = (ia >= 8) ? ia - 16 : ia;
    sb     = (ib >= 8) ? ib - 16 : ib;
    diff   = sa - sb - ibin;
    r.ovf  = (diff < -8 || diff > 7) ? 1 : 0;
    return r;
  endfunction

  // Compare process: tracks acceptances and checks every result cycle.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("mon_d", int'(d), exp_q[0].d);
          chk("mon_bout", int'(bout), exp_q[0].bout);
          chk("mon_ovf", int'(ovf), exp_q[0].ovf);
          chk("mon_in_ready_low", int'(in_ready), 0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(a), int'(b), int'(bin)));
    end
  end

  task automatic accept(input logic [3:0] ia, input logic [3:0] ib, input logic ibin, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk({tag, "_ready_timeout"}, 0, 1);
    in_valid = 1'b1;
    a = ia;
    b = ib;
    bin = ibin;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                       input int hold, input int glitch,
                       input int ed, input int eb, input int eo, input string tag);
    int lat;
    logic [3:0] d0;
    logic b0, o0;
    accept(ia, ib, ibin, tag);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
      if (lat == 2) chk({tag, "_busy_in_ready"}, int'(in_ready), 0);
      if (glitch != 0 && lat == 1) begin
        in_valid = 1'b1;
        a = 4'd1;
        b = 4'd1;
        bin = 1'b0;
      end
      if (lat == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 4);
    if (!out_valid) return;
    @(negedge clk);
    chk({tag, "_d"}, int'(d), ed);
    chk({tag, "_bout"}, int'(bout), eb);
    chk({tag, "_ovf"}, int'(ovf), eo);
    d0 = d;
    b0 = bout;
    o0 = ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, int'(out_valid), 1);
      chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
      chk({tag, "_hold_d"}, int'(d), int'(d0));
      chk({tag, "_hold_bout"}, int'(bout), int'(b0));
      chk({tag, "_hold_ovf"}, int'(ovf), int'(o0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_post_in_ready"}, int'(in_ready), 1);
    chk({tag, "_post_valid"}, int'(out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_d", int'(d), 0);
    chk("rst_bout", int'(bout), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;

    do_op(4'd9, 4'd3, 1'b0, 0, 0, 6, 0, 1, "sub_9_3");
    do_op(4'd3, 4'd5, 1'b0, 0, 0, 14, 1, 0, "borrow_3_5");
    do_op(4'd0, 4'd0, 1'b1, 0, 0, 15, 1, 0, "bin_0_0");
    do_op(4'd12, 4'd5, 1'b1, 3, 0, 6, 0, 1, "backpressure");
    do_op(4'd6, 4'd10, 1'b0, 0, 1, 12, 1, 1, "ignored_input");
    do_op(4'd8, 4'd8, 1'b1, 0, 0, 15, 1, 0, "eq_bin");

    // Reset in the middle of an operation.
    accept(4'd9, 4'd3, 1'b0, "midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_d", int'(d), 0);
    chk("midrst_bout", int'(bout), 0);
    chk("midrst_ovf", int'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", int'(out_valid), 0);
    end

    do_op(4'd7, 4'd2, 1'b0, 0, 0, 5, 0, 0, "after_rst");

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
